uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_fifo.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encoding and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO: power-of-two depth, push and pop in the same cycle both take effect even when full.
module rx_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iPush,
  input  logic [W-1:0]             ivDin,
  input  logic                     iPop,
  output logic [W-1:0]             ovDout,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic [$clog2(DEPTH):0]   ovLevel
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [LVL_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign oEmpty    = (r_cnt == '0);
  assign oFull     = (r_cnt == LVL_W'(DEPTH));
  assign w_do_pop  = iPop && !oEmpty;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign w_do_push = iPush && (!oFull || w_do_pop);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + LVL_W'(1);
        2'b01:   r_cnt <= r_cnt - LVL_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (w_do_push) r_mem[r_wr] <= ivDin;
  end

  assign ovDout  = r_mem[r_rd];
  assign ovLevel = r_cnt;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with optional parity and a receive FIFO carrying per-character error flags.
// Define UART_RX_BREAK_EN to detect break conditions (oBreak pulse) instead of pushing them.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PARITY = PAR_EVEN
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iCE,
  input  logic                   iDatos,
  input  logic                   iRead,
  input  logic                   iClrErr,
  output logic [DATA_W-1:0]      ovDato,
  output logic                   oParErr,
  output logic                   oFrmErr,
  output logic                   oValid,
  output logic                   oFull,
  output logic                   oOverrun,
  output logic [$clog2(DEPTH):0] ovLevel
`ifdef UART_RX_BREAK_EN
  ,
  output logic                   oBreak
`endif
);

  localparam int unsigned TICK_W = $clog2(OVS);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned ENT_W  = DATA_W + 2;

  rx_state_e          r_state, w_next;
  logic [1:0]         r_sync;
  logic               w_rx;
  logic [TICK_W-1:0]  r_tick;
  logic [BIT_W-1:0]   r_bit;
  logic [DATA_W-1:0]  r_shift;
  logic               r_par_err;
  logic               r_push;
  logic [ENT_W-1:0]   r_push_data;
  logic               r_overrun;
  logic               w_mid, w_end, w_last_bit, w_par_exp;
  logic               w_tick_clr, w_tick_inc, w_sample;
  logic               w_brk_wait, w_is_break;
  logic               w_pop, w_full, w_empty;
  logic [ENT_W-1:0]   w_head;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], iDatos};
  end
  assign w_rx = r_sync[1];

  assign w_mid      = (r_tick == TICK_W'(OVS / 2 - 1));
  assign w_end      = (r_tick == TICK_W'(OVS - 1));
  assign w_last_bit = (r_bit == BIT_W'(DATA_W - 1));
  assign w_par_exp  = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (iCE && !w_rx && !w_brk_wait) w_next = ST_START;
      ST_START: if (iCE && w_mid) w_next = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (iCE && w_end && w_last_bit)
                  w_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (iCE && w_end) w_next = ST_STOP;
      ST_STOP:  if (iCE && w_end) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Tick counter control and bit-centre sample strobe
  always_comb begin
    w_tick_clr = 1'b0;
    w_tick_inc = 1'b0;
    w_sample   = 1'b0;
    case (r_state)
      ST_IDLE:  w_tick_clr = 1'b1;
      ST_START: if (iCE) begin
                  if (w_mid) w_tick_clr = 1'b1;
                  else       w_tick_inc = 1'b1;
                end
      default:  if (iCE) begin
                  if (w_end) begin
                    w_tick_clr = 1'b1;
                    w_sample   = 1'b1;
                  end else begin
                    w_tick_inc = 1'b1;
                  end
                end
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_tick_clr)      r_tick <= '0;
      else if (w_tick_inc) r_tick <= r_tick + TICK_W'(1);
      if (r_state == ST_START) begin
        r_bit     <= '0;
        r_par_err <= 1'b0;
      end
      if (w_sample) begin
        case (r_state)
          ST_DATA: begin
            r_shift <= {w_rx, r_shift[DATA_W-1:1]};
            r_bit   <= r_bit + BIT_W'(1);
          end
          ST_PAR:  r_par_err <= w_rx ^ w_par_exp;
          ST_STOP: begin
            r_push      <= !w_is_break;
            r_push_data <= {!w_rx, r_par_err, r_shift};
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_BREAK_EN
  logic r_par_bit, r_brk_wait, r_break;

  assign w_brk_wait = r_brk_wait;
  assign w_is_break = !w_rx && (r_shift == '0) && !r_par_bit;
  assign oBreak     = r_break;

  // After a break the line must return high before a new start bit is accepted
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_par_bit  <= 1'b0;
      r_brk_wait <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_break <= 1'b0;
      if (r_state == ST_START)                   r_par_bit <= 1'b0;
      else if (w_sample && r_state == ST_PAR)    r_par_bit <= w_rx;
      if (w_sample && r_state == ST_STOP && w_is_break) begin
        r_break    <= 1'b1;
        r_brk_wait <= 1'b1;
      end else if (r_state == ST_IDLE && w_rx) begin
        r_brk_wait <= 1'b0;
      end
    end
  end
`else
  assign w_brk_wait = 1'b0;
  assign w_is_break = 1'b0;
`endif

  assign w_pop = iRead && !w_empty;

  rx_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iClk    (iClk),
    .iReset  (iReset),
    .iPush   (r_push),
    .ivDin   (r_push_data),
    .iPop    (w_pop),
    .ovDout  (w_head),
    .oFull   (w_full),
    .oEmpty  (w_empty),
    .ovLevel (ovLevel)
  );

  // Overrun is sticky; a coincident loss beats the clear
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)                           r_overrun <= 1'b0;
    else if (r_push && w_full && !w_pop)  r_overrun <= 1'b1;
    else if (iClrErr)                     r_overrun <= 1'b0;
  end

  assign oValid   = !w_empty;
  assign oFull    = w_full;
  assign oOverrun = r_overrun;
  assign ovDato   = oValid ? w_head[DATA_W-1:0] : '0;
  assign oParErr  = oValid && w_head[DATA_W];
  assign oFrmErr  = oValid && w_head[DATA_W+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default instance plus a 7-bit odd-parity OVS=8 instance.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst, ce, rx0, rx1, rd0, clr0, rd1, clr1;
  logic [7:0] dat0;
  logic       par0, frm0, val0, full0, ovr0;
  logic [2:0] lvl0;
  logic [6:0] dat1;
  logic       par1, frm1, val1, full1, ovr1;
  logic [2:0] lvl1;
  int         n_checks, n_errors, lat;
`ifdef UART_RX_BREAK_EN
  logic       brk0, brk1;
  int         brk_cnt = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ce = 1'b0;
  always @(negedge clk) ce = ~ce;

`ifdef UART_RX_BREAK_EN
  always @(negedge clk) if (brk0) brk_cnt++;
`endif

  uart_rx_fifo u_dut0 (
    .iClk(clk), .iReset(rst), .iCE(ce), .iDatos(rx0), .iRead(rd0), .iClrErr(clr0),
    .ovDato(dat0), .oParErr(par0), .oFrmErr(frm0), .oValid(val0), .oFull(full0),
    .oOverrun(ovr0), .ovLevel(lvl0)
`ifdef UART_RX_BREAK_EN
    , .oBreak(brk0)
`endif
  );

  uart_rx_fifo #(.DATA_W(7), .OVS(8), .DEPTH(4), .PARITY(2)) u_dut1 (
    .iClk(clk), .iReset(rst), .iCE(ce), .iDatos(rx1), .iRead(rd1), .iClrErr(clr1),
    .ovDato(dat1), .oParErr(par1), .oFrmErr(frm1), .oValid(val1), .oFull(full1),
    .oOverrun(ovr1), .ovLevel(lvl1)
`ifdef UART_RX_BREAK_EN
    , .oBreak(brk1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!ce) @(posedge clk);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    #1;
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic pop0();
    @(negedge clk); rd0 = 1'b1;
    @(negedge clk); rd0 = 1'b0;
  endtask

  // mode 0: plain, 1: record push latency from stop-bit start, 2: pop on the push edge
  task automatic send_frame(input int sel, input logic [8:0] d, input bit badpar,
                            input bit stopv, input int mode);
    int   nb, ovs;
    logic p;
    nb  = (sel != 0) ? 7 : 8;
    ovs = (sel != 0) ? 8 : 16;
    p   = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    if (sel != 0) p = ~p;
    if (badpar)   p = ~p;
    wait_ticks(1);
    drive(sel, 1'b0); wait_ticks(ovs);
    for (int i = 0; i < nb; i++) begin
      drive(sel, d[i]); wait_ticks(ovs);
    end
    drive(sel, p); wait_ticks(ovs);
    drive(sel, stopv);
    if (!stopv) begin
      wait_ticks(ovs / 2 + 2);
    end else if (mode == 1) begin
      lat = 0;
      for (int k = 1; k <= 200; k++) begin
        @(negedge clk);
        if (val0) begin
          lat = k;
          break;
        end
      end
      check("push_seen", 32'(lat > 0), 32'd1);
      wait_ticks(ovs);
    end else if (mode == 2) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        if (k == lat - 1) rd0 = 1'b1;
      end
      rd0 = 1'b0;
      wait_ticks(ovs);
    end else begin
      wait_ticks(ovs);
    end
    drive(sel, 1'b1);
    wait_ticks(2 * ovs);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; lat = 0;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rd0 = 1'b0; clr0 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(val0), 32'd0);
    check("rst_level", 32'(lvl0), 32'd0);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_overrun", 32'(ovr0), 32'd0);
    check("rst_dato", 32'(dat0), 32'd0);
    check("rst_flags", 32'({par0, frm0}), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    send_frame(0, 9'h0A5, 1'b0, 1'b1, 1);
    check("a5_dato", 32'(dat0), 32'hA5);
    check("a5_flags", 32'({frm0, par0}), 32'd0);
    check("a5_level", 32'(lvl0), 32'd1);
    pop0();
    @(negedge clk);
    check("empty_level", 32'(lvl0), 32'd0);
    check("empty_valid", 32'(val0), 32'd0);
    check("empty_dato", 32'(dat0), 32'd0);

    send_frame(0, 9'h03C, 1'b1, 1'b1, 0);
    check("3c_dato", 32'(dat0), 32'h3C);
    check("3c_parerr", 32'(par0), 32'd1);
    check("3c_frmerr", 32'(frm0), 32'd0);
    pop0();

    send_frame(0, 9'h055, 1'b0, 1'b0, 0);
    check("55_dato", 32'(dat0), 32'h55);
    check("55_frmerr", 32'(frm0), 32'd1);
    check("55_parerr", 32'(par0), 32'd0);
    check("55_level", 32'(lvl0), 32'd1);
    pop0();

    wait_ticks(1);
    drive(0, 1'b0); wait_ticks(4);
    drive(0, 1'b1); wait_ticks(40);
    @(negedge clk);
    check("glitch_level", 32'(lvl0), 32'd0);
    check("glitch_valid", 32'(val0), 32'd0);

    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 1'b1, 0);
    check("ovr_full", 32'(full0), 32'd1);
    check("ovr_level", 32'(lvl0), 32'd4);
    check("ovr_flag", 32'(ovr0), 32'd1);
    check("ovr_head", 32'(dat0), 32'h01);
    @(negedge clk); clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0;
    check("clr_overrun", 32'(ovr0), 32'd0);

    send_frame(0, 9'h005, 1'b0, 1'b1, 2);
    check("rdpush_level", 32'(lvl0), 32'd4);
    check("rdpush_full", 32'(full0), 32'd1);
    check("rdpush_overrun", 32'(ovr0), 32'd0);
    check("rdpush_head", 32'(dat0), 32'h02);
    for (int i = 2; i <= 5; i++) begin
      check("drain_data", 32'(dat0), 32'(i));
      pop0();
      @(negedge clk);
    end
    check("drain_level", 32'(lvl0), 32'd0);

    send_frame(0, 9'h077, 1'b0, 1'b1, 0);
    check("pre_rst_level", 32'(lvl0), 32'd1);
    wait_ticks(1);
    drive(0, 1'b0); wait_ticks(16);
    drive(0, 1'b1); wait_ticks(40);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_level", 32'(lvl0), 32'd0);
    check("midrst_valid", 32'(val0), 32'd0);
    check("midrst_dato", 32'(dat0), 32'd0);
    @(negedge clk); rst = 1'b0;
    wait_ticks(40);
    @(negedge clk);
    check("postrst_level", 32'(lvl0), 32'd0);
    send_frame(0, 9'h012, 1'b0, 1'b1, 0);
    check("12_level", 32'(lvl0), 32'd1);
    check("12_dato", 32'(dat0), 32'h12);
    pop0();

    send_frame(0, 9'h000, 1'b0, 1'b0, 0);
`ifdef UART_RX_BREAK_EN
    check("brk_pulses", 32'(brk_cnt), 32'd1);
    check("brk_level", 32'(lvl0), 32'd0);
    send_frame(0, 9'h033, 1'b0, 1'b1, 0);
    check("after_brk_dato", 32'(dat0), 32'h33);
    check("after_brk_level", 32'(lvl0), 32'd1);
`else
    check("brk_level", 32'(lvl0), 32'd1);
    check("brk_dato", 32'(dat0), 32'd0);
    check("brk_frmerr", 32'(frm0), 32'd1);
    check("brk_parerr", 32'(par0), 32'd0);
`endif
    pop0();

    @(negedge clk);
    check("d1_idle_level", 32'(lvl1), 32'd0);
    send_frame(1, 9'h041, 1'b0, 1'b1, 0);
    check("d1_dato", 32'(dat1), 32'h41);
    check("d1_flags", 32'({frm1, par1}), 32'd0);
    check("d1_level", 32'(lvl1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
